// File: rtl/core_mem_responder.sv
// Core data-memory responder: one outstanding core word request at a time, run as an Avalon-MM master transfer.
// Optional range check on the word address is compiled in with `define CORE_MEM_BOUNDS_EN.
module core_mem_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [29:0] BASE_WORD      = 30'h0,
  parameter logic [30:0] SIZE_WORDS     = 31'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_start,
  input  logic        mem_write,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_data_wr,
  input  logic [3:0]  mem_data_be,
  output logic        mem_ready,
  output logic        mem_fault,
  output logic [31:0] mem_data_rd,
  output logic [31:0] avl_address,
  output logic        avl_read,
  output logic        avl_write,
  output logic [31:0] avl_writedata,
  output logic [3:0]  avl_byteenable,
  input  logic        avl_waitrequest,
  input  logic [31:0] avl_readdata,
  input  logic        avl_readdatavalid,
  input  logic [1:0]  avl_response
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

`ifdef CORE_MEM_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  state_t      state_q, state_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        discard_q, discard_d;
  logic        mem_ready_q, mem_ready_d;
  logic        mem_fault_q, mem_fault_d;
  logic [31:0] mem_data_rd_q, mem_data_rd_d;
  logic [31:0] avl_address_q, avl_address_d;
  logic        avl_read_q, avl_read_d;
  logic        avl_write_q, avl_write_d;
  logic [31:0] avl_writedata_q, avl_writedata_d;
  logic [3:0]  avl_byteenable_q, avl_byteenable_d;

  logic [29:0] range_off;
  logic        out_of_range;
  logic        tmo_hit;

  // The window size is one bit wider than the address so a full 2^30-word window is expressible.
  assign range_off    = mem_addr - BASE_WORD;
  assign out_of_range = BOUNDS_EN && ({1'b0, range_off} >= SIZE_WORDS);
  assign tmo_hit      = TMO_EN && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d          = state_q;
    tmo_cnt_d        = tmo_cnt_q;
    discard_d        = discard_q;
    mem_ready_d      = 1'b0;
    mem_fault_d      = 1'b0;
    mem_data_rd_d    = mem_data_rd_q;
    avl_address_d    = avl_address_q;
    avl_read_d       = avl_read_q;
    avl_write_d      = avl_write_q;
    avl_writedata_d  = avl_writedata_q;
    avl_byteenable_d = avl_byteenable_q;

    // A beat belonging to a timed-out read is swallowed wherever it shows up.
    if (avl_readdatavalid && discard_q) begin
      discard_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (mem_start) begin
          if (out_of_range) begin
            mem_ready_d = 1'b1;
            mem_fault_d = 1'b1;
          end else begin
            state_d          = ISSUE;
            tmo_cnt_d        = 16'd0;
            avl_address_d    = {mem_addr, 2'b00};
            avl_read_d       = ~mem_write;
            avl_write_d      = mem_write;
            avl_writedata_d  = mem_data_wr;
            avl_byteenable_d = mem_write ? mem_data_be : 4'b1111;
          end
        end
      end
      ISSUE: begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        if (!avl_waitrequest) begin
          avl_read_d  = 1'b0;
          avl_write_d = 1'b0;
          if (avl_write_q) begin
            mem_ready_d = 1'b1;
            mem_fault_d = (avl_response != 2'b00);
            state_d     = IDLE;
          end else begin
            state_d = RDWAIT;
          end
        end else if (tmo_hit) begin
          avl_read_d  = 1'b0;
          avl_write_d = 1'b0;
          mem_ready_d = 1'b1;
          mem_fault_d = 1'b1;
          state_d     = IDLE;
        end
      end
      RDWAIT: begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        if (avl_readdatavalid && !discard_q) begin
          mem_ready_d = 1'b1;
          state_d     = IDLE;
          if (avl_response == 2'b00) begin
            mem_data_rd_d = avl_readdata;
          end else begin
            mem_fault_d = 1'b1;
          end
        end else if (tmo_hit) begin
          mem_ready_d = 1'b1;
          mem_fault_d = 1'b1;
          discard_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      tmo_cnt_q        <= 16'd0;
      discard_q        <= 1'b0;
      mem_ready_q      <= 1'b0;
      mem_fault_q      <= 1'b0;
      mem_data_rd_q    <= 32'd0;
      avl_address_q    <= 32'd0;
      avl_read_q       <= 1'b0;
      avl_write_q      <= 1'b0;
      avl_writedata_q  <= 32'd0;
      avl_byteenable_q <= 4'd0;
    end else begin
      state_q          <= state_d;
      tmo_cnt_q        <= tmo_cnt_d;
      discard_q        <= discard_d;
      mem_ready_q      <= mem_ready_d;
      mem_fault_q      <= mem_fault_d;
      mem_data_rd_q    <= mem_data_rd_d;
      avl_address_q    <= avl_address_d;
      avl_read_q       <= avl_read_d;
      avl_write_q      <= avl_write_d;
      avl_writedata_q  <= avl_writedata_d;
      avl_byteenable_q <= avl_byteenable_d;
    end
  end

  assign mem_ready      = mem_ready_q;
  assign mem_fault      = mem_fault_q;
  assign mem_data_rd    = mem_data_rd_q;
  assign avl_address    = avl_address_q;
  assign avl_read       = avl_read_q;
  assign avl_write      = avl_write_q;
  assign avl_writedata  = avl_writedata_q;
  assign avl_byteenable = avl_byteenable_q;

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: directed scenarios plus randomized traffic against a word-memory reference.
// Inputs change and outputs are sampled on the falling edge; the DUT registers on the rising edge.
module tb_core_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_start, mem_write;
  logic [29:0] mem_addr;
  logic [31:0] mem_data_wr;
  logic [3:0]  mem_data_be;
  logic        mem_ready, mem_fault;
  logic [31:0] mem_data_rd;
  logic [31:0] avl_address;
  logic        avl_read, avl_write;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic        avl_waitrequest;
  logic [31:0] avl_readdata;
  logic        avl_readdatavalid;
  logic [1:0]  avl_response;

  int checks = 0;
  int errors = 0;

`ifdef CORE_MEM_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic [31:0] ref_mem   [16];
  logic [31:0] slave_mem [16];
  logic [31:0] exp_rd;
  bit          rd_known;

  core_mem_responder #(
    .TIMEOUT_CYCLES(8),
    .BASE_WORD     (30'h1000),
    .SIZE_WORDS    (31'h100)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_start        (mem_start),
    .mem_write        (mem_write),
    .mem_addr         (mem_addr),
    .mem_data_wr      (mem_data_wr),
    .mem_data_be      (mem_data_be),
    .mem_ready        (mem_ready),
    .mem_fault        (mem_fault),
    .mem_data_rd      (mem_data_rd),
    .avl_address      (avl_address),
    .avl_read         (avl_read),
    .avl_write        (avl_write),
    .avl_writedata    (avl_writedata),
    .avl_byteenable   (avl_byteenable),
    .avl_waitrequest  (avl_waitrequest),
    .avl_readdata     (avl_readdata),
    .avl_readdatavalid(avl_readdatavalid),
    .avl_response     (avl_response)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    mem_start = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_data_wr = '0; mem_data_be = '0;
    avl_waitrequest = 1'b0; avl_readdata = '0; avl_readdatavalid = 1'b0; avl_response = 2'b00;
  endtask

  task automatic start_req(input logic we, input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
    mem_start = 1'b1; mem_write = we; mem_addr = a; mem_data_wr = d; mem_data_be = be;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    quiet_inputs();
    repeat (3) step();
    checks++;
    if ({mem_ready, mem_fault, mem_data_rd, avl_address, avl_read, avl_write, avl_writedata, avl_byteenable} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b fault=%b rd=%h addr=%h r=%b w=%b wd=%h be=%b required all zero",
               mem_ready, mem_fault, mem_data_rd, avl_address, avl_read, avl_write, avl_writedata, avl_byteenable);
    end
    rst = 1'b0;
    step();
    $display("txn reset done");
  endtask

  task automatic test_zero_wait_write();
    start_req(1'b1, 30'h100, 32'hDEADBEEF, 4'b0011);
    step();
    mem_start = 1'b0;
    checks++;
    if ({avl_write, avl_read, avl_address, avl_byteenable, avl_writedata, mem_ready} !== {1'b1, 1'b0, 32'h400, 4'b0011, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL wr_issue: got w=%b r=%b addr=%h be=%b wd=%h ready=%b required w=1 r=0 addr=400 be=0011 wd=deadbeef ready=0",
               avl_write, avl_read, avl_address, avl_byteenable, avl_writedata, mem_ready);
    end
    step();
    checks++;
    if ({mem_ready, mem_fault, avl_write} !== 3'b100) begin
      errors++;
      $display("FAIL wr_ready: got ready=%b fault=%b w=%b required ready=1 fault=0 w=0", mem_ready, mem_fault, avl_write);
    end
    step();
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_ready_pulse: got ready=%b required 0", mem_ready);
    end
    $display("txn zero-wait write addr=100 data=deadbeef");
  endtask

  task automatic test_wait_read();
    start_req(1'b0, 30'h200, 32'h0, 4'b0000);
    avl_waitrequest = 1'b1;
    step();
    mem_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({avl_read, avl_write, avl_address, avl_byteenable, mem_ready} !== {1'b1, 1'b0, 32'h800, 4'b1111, 1'b0}) begin
        errors++;
        $display("FAIL rd_hold_%0d: got r=%b w=%b addr=%h be=%b ready=%b required r=1 w=0 addr=800 be=1111 ready=0",
                 k, avl_read, avl_write, avl_address, avl_byteenable, mem_ready);
      end
      avl_waitrequest = (k < 4);
      step();
    end
    checks++;
    if ({avl_read, mem_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rd_release: got r=%b ready=%b required 0 0", avl_read, mem_ready);
    end
    step();
    avl_readdatavalid = 1'b1; avl_readdata = 32'hCAFEF00D; avl_response = 2'b00;
    step();
    avl_readdatavalid = 1'b0; avl_readdata = 32'h0;
    checks++;
    if ({mem_ready, mem_fault, mem_data_rd} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL rd_done: got ready=%b fault=%b rd=%h required 1 0 cafef00d", mem_ready, mem_fault, mem_data_rd);
    end
    step();
    checks++;
    if ({mem_ready, mem_data_rd} !== {1'b0, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL rd_hold_data: got ready=%b rd=%h required 0 cafef00d", mem_ready, mem_data_rd);
    end
    exp_rd = 32'hCAFEF00D; rd_known = 1'b1;
    $display("txn waited read addr=200 data=cafef00d");
  endtask

  task automatic test_error_read();
    start_req(1'b0, 30'h300, 32'h0, 4'b0000);
    step();
    mem_start = 1'b0; avl_waitrequest = 1'b0;
    step();
    avl_readdatavalid = 1'b1; avl_response = 2'b10; avl_readdata = 32'h12345678;
    step();
    avl_readdatavalid = 1'b0; avl_response = 2'b00; avl_readdata = 32'h0;
    checks++;
    if ({mem_ready, mem_fault, mem_data_rd} !== {1'b1, 1'b1, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL rd_error: got ready=%b fault=%b rd=%h required 1 1 cafef00d", mem_ready, mem_fault, mem_data_rd);
    end
    step();
    checks++;
    if ({mem_ready, mem_fault} !== 2'b00) begin
      errors++;
      $display("FAIL rd_error_pulse: got ready=%b fault=%b required 0 0", mem_ready, mem_fault);
    end
    $display("txn error read addr=300 response=10");
  endtask

  task automatic test_idle_rdv();
    avl_readdatavalid = 1'b1; avl_readdata = 32'h00000BAD; avl_response = 2'b00;
    step();
    avl_readdatavalid = 1'b0; avl_readdata = 32'h0;
    step();
    checks++;
    if ({mem_ready, mem_data_rd} !== {1'b0, exp_rd}) begin
      errors++;
      $display("FAIL idle_rdv: got ready=%b rd=%h required 0 %h", mem_ready, mem_data_rd, exp_rd);
    end
    $display("txn stray readdatavalid in idle");
  endtask

  task automatic test_timeout_back_to_back();
    start_req(1'b0, 30'h40, 32'h0, 4'b0000);
    step();
    mem_start = 1'b0; avl_waitrequest = 1'b0;
    checks++;
    if (avl_read !== 1'b1) begin
      errors++;
      $display("FAIL tmo_issue: got r=%b required 1", avl_read);
    end
    step();
    for (int k = 2; k <= 8; k++) begin
      checks++;
      if ({mem_ready, avl_read} !== 2'b00) begin
        errors++;
        $display("FAIL tmo_wait_%0d: got ready=%b r=%b required 0 0", k, mem_ready, avl_read);
      end
      step();
    end
    checks++;
    if ({mem_ready, mem_fault} !== 2'b11) begin
      errors++;
      $display("FAIL tmo_fire: got ready=%b fault=%b required 1 1", mem_ready, mem_fault);
    end
    start_req(1'b0, 30'h41, 32'h0, 4'b0000);
    step();
    mem_start = 1'b0;
    checks++;
    if ({avl_read, avl_address, mem_ready} !== {1'b1, 32'h104, 1'b0}) begin
      errors++;
      $display("FAIL b2b_issue: got r=%b addr=%h ready=%b required 1 104 0", avl_read, avl_address, mem_ready);
    end
    step();
    avl_readdatavalid = 1'b1; avl_readdata = 32'h1;
    step();
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL stale_discard: got ready=%b rd=%h required ready 0", mem_ready, mem_data_rd);
    end
    avl_readdata = 32'h2;
    step();
    avl_readdatavalid = 1'b0; avl_readdata = 32'h0;
    checks++;
    if ({mem_ready, mem_fault, mem_data_rd} !== {1'b1, 1'b0, 32'h2}) begin
      errors++;
      $display("FAIL after_tmo_read: got ready=%b fault=%b rd=%h required 1 0 00000002", mem_ready, mem_fault, mem_data_rd);
    end
    exp_rd = 32'h2;
    step();
    $display("txn timeout read then back-to-back read data=2");
  endtask

  task automatic test_reset_mid_write();
    start_req(1'b1, 30'h55, 32'hA5A5A5A5, 4'b1111);
    avl_waitrequest = 1'b1;
    step();
    mem_start = 1'b0;
    checks++;
    if (avl_write !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_issue: got w=%b required 1", avl_write);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; avl_waitrequest = 1'b0;
    checks++;
    if ({mem_ready, mem_fault, mem_data_rd, avl_address, avl_read, avl_write, avl_writedata, avl_byteenable} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got ready=%b w=%b addr=%h wd=%h rd=%h required all zero",
               mem_ready, avl_write, avl_address, avl_writedata, mem_data_rd);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({mem_ready, avl_write} !== 2'b00) begin
        errors++;
        $display("FAIL rstmid_no_ready_%0d: got ready=%b w=%b required 0 0", k, mem_ready, avl_write);
      end
    end
    start_req(1'b0, 30'h60, 32'h0, 4'b0000);
    step();
    mem_start = 1'b0;
    step();
    avl_readdatavalid = 1'b1; avl_readdata = 32'h7777;
    step();
    avl_readdatavalid = 1'b0; avl_readdata = 32'h0;
    checks++;
    if ({mem_ready, mem_fault, mem_data_rd} !== {1'b1, 1'b0, 32'h7777}) begin
      errors++;
      $display("FAIL rstmid_fresh_read: got ready=%b fault=%b rd=%h required 1 0 00007777", mem_ready, mem_fault, mem_data_rd);
    end
    exp_rd = 32'h7777;
    step();
    $display("txn reset during write wait, then fresh read");
  endtask

  task automatic test_bounds();
    logic [29:0] addrs [4];
    logic [29:0] a;
    logic [29:0] off;
    logic        in_range;
    addrs[0] = 30'h1100; addrs[1] = 30'h10FF; addrs[2] = 30'h0FFF; addrs[3] = 30'h1000;
    for (int i = 0; i < 4; i++) begin
      a        = addrs[i];
      off      = a - 30'h1000;
      in_range = !BOUNDS_EN || (off < 30'h100);
      start_req(1'b0, a, 32'h0, 4'b0000);
      step();
      mem_start = 1'b0;
      if (in_range) begin
        checks++;
        if ({avl_read, avl_address, mem_ready} !== {1'b1, a, 2'b00, 1'b0}) begin
          errors++;
          $display("FAIL bounds_in_%h: got r=%b addr=%h ready=%b required r=1 addr=%h ready=0", a, avl_read, avl_address, mem_ready, {a, 2'b00});
        end
        step();
        avl_readdatavalid = 1'b1; avl_readdata = {2'b00, a};
        step();
        avl_readdatavalid = 1'b0; avl_readdata = 32'h0;
        checks++;
        if ({mem_ready, mem_fault, mem_data_rd} !== {1'b1, 1'b0, 2'b00, a}) begin
          errors++;
          $display("FAIL bounds_in_done_%h: got ready=%b fault=%b rd=%h required 1 0 %h", a, mem_ready, mem_fault, mem_data_rd, {2'b00, a});
        end
        exp_rd = {2'b00, a};
      end else begin
        checks++;
        if ({avl_read, avl_write, mem_ready, mem_fault} !== 4'b0011) begin
          errors++;
          $display("FAIL bounds_out_%h: got r=%b w=%b ready=%b fault=%b required 0 0 1 1", a, avl_read, avl_write, mem_ready, mem_fault);
        end
      end
      step();
      $display("txn bounds read addr=%h in_range=%0b", a, in_range);
    end
  endtask

  task automatic test_random();
    logic        we, err;
    int          idx, w, lat;
    logic [29:0] a;
    logic [31:0] d, mask;
    logic [3:0]  be;
    logic [3:0]  sidx;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'h0; slave_mem[i] = 32'h0;
    end
    for (int n = 0; n < 150; n++) begin
      we  = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 15);
      a   = 30'h1000 + 30'(idx);
      d   = $urandom;
      be  = 4'($urandom_range(0, 15));
      w   = $urandom_range(0, 3);
      lat = $urandom_range(0, 2);
      err = ($urandom_range(0, 7) == 0);
      start_req(we, a, d, be);
      avl_waitrequest = (w > 0); avl_readdatavalid = 1'b0; avl_response = 2'b00;
      step();
      mem_start = 1'b0;
      sidx = 4'h0;
      for (int k = 0; k <= w; k++) begin
        checks++;
        if ({avl_read, avl_write, avl_address, avl_byteenable, mem_ready} !== {~we, we, a, 2'b00, (we ? be : 4'b1111), 1'b0} ||
            (we && avl_writedata !== d)) begin
          errors++;
          $display("FAIL rnd_issue_%0d: got r=%b w=%b addr=%h be=%b wd=%h ready=%b required r=%b w=%b addr=%h be=%b wd=%h ready=0",
                   n, avl_read, avl_write, avl_address, avl_byteenable, avl_writedata, mem_ready,
                   ~we, we, {a, 2'b00}, (we ? be : 4'b1111), d);
        end
        avl_waitrequest = (k < w);
        if (k == w) begin
          sidx = avl_address[5:2];
          avl_response = (we && err) ? 2'b10 : 2'b00;
          if (we && !err) begin
            for (int b = 0; b < 4; b++)
              if (avl_byteenable[b]) slave_mem[sidx][8*b +: 8] = avl_writedata[8*b +: 8];
          end
        end
        step();
      end
      avl_waitrequest = 1'b0; avl_response = 2'b00;
      if (!we) begin
        for (int k = 0; k < lat; k++) begin
          checks++;
          if ({mem_ready, avl_read} !== 2'b00) begin
            errors++;
            $display("FAIL rnd_rdwait_%0d: got ready=%b r=%b required 0 0", n, mem_ready, avl_read);
          end
          step();
        end
        avl_readdatavalid = 1'b1;
        avl_response      = err ? 2'b10 : 2'b00;
        avl_readdata      = err ? $urandom : slave_mem[sidx];
        step();
        avl_readdatavalid = 1'b0; avl_response = 2'b00; avl_readdata = 32'h0;
      end
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      if (we && !err) ref_mem[idx] = (ref_mem[idx] & ~mask) | (d & mask);
      if (!we && !err) begin
        exp_rd = ref_mem[idx]; rd_known = 1'b1;
      end
      checks++;
      if ({mem_ready, mem_fault} !== {1'b1, err} || (rd_known && mem_data_rd !== exp_rd)) begin
        errors++;
        $display("FAIL rnd_done_%0d: got ready=%b fault=%b rd=%h required ready=1 fault=%b rd=%h",
                 n, mem_ready, mem_fault, mem_data_rd, err, exp_rd);
      end
      $display("txn %0d we=%0b addr=%h be=%b data=%h waits=%0d lat=%0d err=%0b", n, we, a, be, (we ? d : exp_rd), w, lat, err);
      if ($urandom_range(0, 1) == 1) begin
        step();
        checks++;
        if (mem_ready !== 1'b0) begin
          errors++;
          $display("FAIL rnd_gap_%0d: got ready=%b required 0", n, mem_ready);
        end
      end
    end
  endtask

  initial begin
    rd_known = 1'b0;
    exp_rd   = 32'h0;
    rst      = 1'b1;
    quiet_inputs();
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_error_read();
    test_idle_rdv();
    test_timeout_back_to_back();
    test_reset_mid_write();
    test_bounds();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
